// File: rtl/ekf_pkg.sv
// Shared EKF constants and gather FSM encoding; the write-back stage reuses the
// address constants.
package ekf_pkg;

   localparam int unsigned X       = 4;
   localparam int unsigned RSA_DW  = 32;
   localparam int unsigned ADDR_DW = 10;
   localparam int unsigned GRP_DW  = 8;
   localparam int unsigned RD_LAT  = 1;

   localparam int unsigned WORD_W = (X > 1) ? $clog2(X) : 1;
   localparam int unsigned LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StDrain,
      StOut,
      StDone
   } gather_st_e;

endpackage

// File: rtl/plb_vec_gather_if.sv
// PLB BRAM port plus the vector valid/ready stream towards the systolic array.
interface plb_vec_gather_if;
   import ekf_pkg::*;

   logic                  plb_en;
   logic                  plb_we;
   logic [ADDR_DW-1:0]    plb_addr;
   logic [RSA_DW-1:0]     plb_dout;
   logic                  vec_valid;
   logic                  vec_ready;
   logic [X*RSA_DW-1:0]   vec_data;

   modport master (
      output plb_en, plb_we, plb_addr, vec_valid, vec_data,
      input  plb_dout, vec_ready
   );

   modport slave (
      input  plb_en, plb_we, plb_addr, vec_valid, vec_data,
      output plb_dout, vec_ready
   );

endinterface

// File: rtl/plb_rd_pipe.sv
// Delay line tagging each BRAM read with its lane so the return lands in the
// right slot of the gather register.
module plb_rd_pipe #(
   parameter int unsigned Depth = 1,
   parameter int unsigned LaneW = 2
) (
   input  logic             clk,
   input  logic             sys_rst,
   input  logic             vld_i,
   input  logic [LaneW-1:0] lane_i,
   output logic             vld_o,
   output logic [LaneW-1:0] lane_o
);

   logic [Depth-1:0]            vld_q;
   logic [Depth-1:0][LaneW-1:0] lane_q;

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         vld_q  <= '0;
         lane_q <= '0;
      end else begin
         vld_q[0]  <= vld_i;
         lane_q[0] <= lane_i;
         for (int i = 1; i < Depth; i++) begin
            vld_q[i]  <= vld_q[i-1];
            lane_q[i] <= lane_q[i-1];
         end
      end
   end

   assign vld_o  = vld_q[Depth-1];
   assign lane_o = lane_q[Depth-1];

endmodule

// File: rtl/plb_vec_gather.sv
// Reads X-word groups from the PLB BRAM and presents each as one packed vector
// with a valid/ready handshake.
module plb_vec_gather
   import ekf_pkg::*;
(
   input  logic               clk,
   input  logic               sys_rst,
   input  logic               start_i,
   input  logic [ADDR_DW-1:0] base_addr_i,
   input  logic [GRP_DW-1:0]  n_grp_i,
   output logic               busy_o,
   output logic               done_o,
   plb_vec_gather_if.master   bus
);

   gather_st_e                state_q, state_d;
   logic [WORD_W-1:0]         word_q, word_d;
   logic [GRP_DW-1:0]         grp_q, grp_d;
   logic [GRP_DW-1:0]         ngrp_q, ngrp_d;
   logic [ADDR_DW-1:0]        addr_q, addr_d;
   logic [LAT_W-1:0]          drain_q, drain_d;
   logic [X-1:0][RSA_DW-1:0]  gather_q, gather_d;
   logic [GRP_DW:0]           grp_nxt;
   logic                      issue;
   logic                      tap_vld;
   logic [WORD_W-1:0]         tap_lane;

   assign issue = (state_q == StIssue);

   plb_rd_pipe #(
      .Depth (RD_LAT),
      .LaneW (WORD_W)
   ) u_rd_pipe (
      .clk     (clk),
      .sys_rst (sys_rst),
      .vld_i   (issue),
      .lane_i  (word_q),
      .vld_o   (tap_vld),
      .lane_o  (tap_lane)
   );

   // Extra bit so n_grp = 2^GRP_DW-1 terminates correctly.
   assign grp_nxt = {1'b0, grp_q} + 1'b1;

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      grp_d   = grp_q;
      ngrp_d  = ngrp_q;
      addr_d  = addr_q;
      drain_d = drain_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               ngrp_d  = n_grp_i;
               addr_d  = base_addr_i;
               grp_d   = '0;
               word_d  = '0;
               state_d = (n_grp_i != '0) ? StIssue : StDone;
            end
         end
         StIssue: begin
            addr_d = addr_q + 1'b1;
            word_d = word_q + 1'b1;
            if (word_q == WORD_W'(X - 1)) begin
               drain_d = '0;
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (drain_q == LAT_W'(RD_LAT - 1)) begin
               state_d = StOut;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         StOut: begin
            if (bus.vec_ready) begin
               if (grp_nxt < {1'b0, ngrp_q}) begin
                  grp_d   = grp_nxt[GRP_DW-1:0];
                  word_d  = '0;
                  state_d = StIssue;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      gather_d = gather_q;
      if (tap_vld) begin
         gather_d[tap_lane] = bus.plb_dout;
      end
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state_q  <= StIdle;
         word_q   <= '0;
         grp_q    <= '0;
         ngrp_q   <= '0;
         addr_q   <= '0;
         drain_q  <= '0;
         gather_q <= '0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         grp_q    <= grp_d;
         ngrp_q   <= ngrp_d;
         addr_q   <= addr_d;
         drain_q  <= drain_d;
         gather_q <= gather_d;
      end
   end

   // Address is gated so the write-back stage sees a quiet port when idle.
   assign bus.plb_en    = issue;
   assign bus.plb_we    = 1'b0;
   assign bus.plb_addr  = issue ? addr_q : '0;
   assign bus.vec_valid = (state_q == StOut);
   assign bus.vec_data  = gather_q;
   assign busy_o        = (state_q != StIdle) && (state_q != StDone);
   assign done_o        = (state_q == StDone);

endmodule

// File: tb/tb_plb_vec_gather.sv
// Randomized self-checking bench: BRAM model with mem[a]=a+0x100 and a
// transaction-level timing/data reference.
module tb_plb_vec_gather;
   import ekf_pkg::*;

   logic               clk;
   logic               sys_rst;
   logic               start;
   logic [ADDR_DW-1:0] base_addr;
   logic [GRP_DW-1:0]  n_grp;
   logic               busy;
   logic               done;
   logic [RSA_DW-1:0]  rdata;
   logic [RSA_DW-1:0]  mem [1024];

   int n_err;
   int n_checks;

   plb_vec_gather_if bus ();

   plb_vec_gather dut (
      .clk         (clk),
      .sys_rst     (sys_rst),
      .start_i     (start),
      .base_addr_i (base_addr),
      .n_grp_i     (n_grp),
      .busy_o      (busy),
      .done_o      (done),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.plb_en) rdata <= mem[bus.plb_addr];
   end
   assign bus.plb_dout = rdata;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] exp_vec(input int base, input int g);
      logic [127:0] v;
      v = '0;
      for (int k = 0; k < X; k++) begin
         v[k*RSA_DW +: RSA_DW] = mem[(base + g*X + k) % 1024];
      end
      return v;
   endfunction

   task automatic check_idle(input string tag);
      check_eq({tag, "_busy"}, busy, 1'b0);
      check_eq({tag, "_done"}, done, 1'b0);
      check_eq({tag, "_en"}, bus.plb_en, 1'b0);
      check_eq({tag, "_valid"}, bus.vec_valid, 1'b0);
   endtask

   // mode 0: ready high; mode 1: stall first vector 10 cycles; mode 2: random ready.
   task automatic run_txn(input int base, input int ng, input int mode, input int dup_cyc);
      int cyc, g, nwords, ndone, exp_done, stall, grp, k, istart, vexp;
      bit first;
      int hs[$];
      bit r;
      @(negedge clk);
      start = 1'b1;
      base_addr = ADDR_DW'(base);
      n_grp = GRP_DW'(ng);
      cyc = 0; g = 0; nwords = 0; ndone = 0; stall = 0; first = 1'b1;
      exp_done = (ng == 0) ? 1 : 32'h4000_0000;
      while (cyc < exp_done && cyc < 2000) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (cyc == dup_cyc) begin
            start = 1'b1;
            base_addr = ADDR_DW'($urandom);
            n_grp = 8'd3;
         end
         check_eq("we", bus.plb_we, 1'b0);
         check_eq("busy", busy, cyc < exp_done);
         check_eq("done", done, cyc == exp_done);
         if (done) ndone++;
         if (bus.plb_en) begin
            grp = nwords / X;
            k = nwords % X;
            if (grp >= ng) istart = -1000;
            else if (grp == 0) istart = 1;
            else if (grp - 1 < hs.size()) istart = hs[grp-1] + 1;
            else istart = -1000;
            check_eq("en_cyc", cyc, istart + k);
            check_eq("addr", bus.plb_addr, (base + nwords) % 1024);
            nwords++;
         end
         if (bus.vec_valid) begin
            check_eq("vec", bus.vec_data, exp_vec(base, g));
            check_eq("vld_done", done, 1'b0);
            check_eq("vld_en", bus.plb_en, 1'b0);
            if (first) begin
               vexp = (g == 0) ? 1 + X + RD_LAT : hs[g-1] + X + RD_LAT + 1;
               check_eq("vld_cyc", cyc, vexp);
               first = 1'b0;
            end
         end
         case (mode)
            1:       r = !(g == 0 && stall < 10);
            2:       r = 1'($urandom_range(0, 1));
            default: r = 1'b1;
         endcase
         if (bus.vec_valid && g == 0) stall++;
         bus.vec_ready = r;
         if (bus.vec_valid && r) begin
            hs.push_back(cyc);
            g++;
            first = 1'b1;
            if (g == ng) exp_done = cyc + 1;
         end
      end
      if (cyc >= 2000) check_eq("timeout", 1'b1, 1'b0);
      check_eq("ndone", ndone, 1);
      check_eq("ngroups", g, ng);
      check_eq("nwords", nwords, ng * X);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         check_idle("post");
      end
   endtask

   initial begin
      n_err = 0;
      n_checks = 0;
      for (int a = 0; a < 1024; a++) mem[a] = RSA_DW'(a + 32'h100);
      sys_rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      n_grp = '0;
      bus.vec_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("rst");
      check_eq("rst_addr", bus.plb_addr, 0);
      check_eq("rst_we", bus.plb_we, 1'b0);
      check_eq("rst_data", bus.vec_data, 0);
      sys_rst = 1'b0;

      run_txn(0, 1, 0, 0);
      run_txn(8, 3, 0, 0);
      run_txn(40, 2, 1, 3);
      run_txn(1022, 1, 0, 0);
      run_txn(100, 0, 0, 1);

      // Reset during DRAIN of the first of two groups.
      @(negedge clk);
      start = 1'b1;
      base_addr = 10'd16;
      n_grp = 8'd2;
      bus.vec_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
      end
      check_eq("pre_rst_busy", busy, 1'b1);
      check_eq("pre_rst_en", bus.plb_en, 1'b0);
      sys_rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_idle("abort");
      check_eq("abort_addr", bus.plb_addr, 0);
      check_eq("abort_data", bus.vec_data, 0);
      sys_rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_idle("after_abort");
      end
      run_txn(200, 2, 0, 0);

      for (int t = 0; t < 8; t++) begin
         run_txn(int'($urandom_range(0, 1023)), int'($urandom_range(0, 5)), 2,
                 int'($urandom_range(1, 4)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
